// File: rtl/bicubic_window_loader_pkg.sv
// Shared definitions for the bicubic window loader and the interpolation
// kernel that unpacks its window.
//   DATA_W  : sample width, matches the demux width
//   SLOTS   : number of window slots (4 rows x 2 columns)
//   state_t : loader FSM encoding
//   slot_row / slot_col : slot index -> (row, column) of the neighbourhood
package bicubic_window_loader_pkg;

  localparam int DATA_W = 15;
  localparam int SLOTS  = 8;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // Slot k sits at row k[2:1], column k[0].
  function automatic logic [1:0] slot_row(input logic [2:0] k);
    return k[2:1];
  endfunction

  function automatic logic slot_col(input logic [2:0] k);
    return k[0];
  endfunction

endpackage

// File: rtl/demux1_8.sv
// 1:8 pixel demultiplexer. Routes one sample to the output lane selected by
// {mux_sel, switch}; all other lanes read zero.
//   data    : incoming sample
//   switch  : column select (lane bit 0)
//   mux_sel : row select (lane bits 2:1)
//   outs    : eight lanes packed, lane k at bits [DATA_W*k +: DATA_W]
module demux1_8 #(
  parameter int DATA_W = 15
) (
  input  logic [DATA_W-1:0]   data,
  input  logic                switch,
  input  logic [1:0]          mux_sel,
  output logic [8*DATA_W-1:0] outs
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the block can leave it unassigned and infer a latch.
    outs = '0;
    outs[int'({mux_sel, switch}) * DATA_W +: DATA_W] = data;
  end

endmodule

// File: rtl/bicubic_window_loader.sv
// Sequencing controller for the bicubic 4x2 window. Steers each accepted
// sample through demux1_8 into the slot addressed by fill_cnt and presents the
// full window downstream with a valid/ready handshake.
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : discard any partial or complete window
//   in_data/in_valid/in_ready : sample stream in
//   win_data/win_valid/win_ready : eight-slot window out, slot k at [15k +: 15]
//   fill_cnt            : index of the next slot to be written
module bicubic_window_loader
  import bicubic_window_loader_pkg::*;
#(
  parameter int DATA_W = bicubic_window_loader_pkg::DATA_W,
  parameter int SLOTS  = bicubic_window_loader_pkg::SLOTS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [SLOTS*DATA_W-1:0] win_data,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [2:0]              fill_cnt
);

  state_t                         state;
  logic [SLOTS-1:0][DATA_W-1:0]   slots;
  logic [SLOTS*DATA_W-1:0]        demux_out;
  logic [SLOTS-1:0]               load_en;
  logic                           accept;
  logic                           switch;
  logic [1:0]                     mux_sel;

  // Select lines follow fill_cnt continuously.
  assign mux_sel = slot_row(fill_cnt);
  assign switch  = slot_col(fill_cnt);

  demux1_8 #(.DATA_W(DATA_W)) u_demux (
    .data    (in_data),
    .switch  (switch),
    .mux_sel (mux_sel),
    .outs    (demux_out)
  );

  // In FULL the loader only takes a sample when the window leaves in the same
  // cycle, which gives back-to-back windows without a bubble.
  always_comb begin
    in_ready = 1'b0;
    if (!flush) in_ready = (state == FILL) || win_ready;
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    load_en = '0;
    for (int k = 0; k < SLOTS; k++) load_en[k] = accept && (fill_cnt == 3'(k));
  end

  // fill_cnt is 0 whenever the FSM is in FULL, so an accept in FULL writes
  // slot 0 and advances to 1 through the same path as an accept in FILL.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst_n || flush) begin
      // NOTE: the slot registers are reset on purpose -- win_data must read
      // zero after reset or flush, so this bank is not treated as plain storage.
      state    <= FILL;
      fill_cnt <= '0;
      slots    <= '0;
    end else begin
      if (accept) fill_cnt <= fill_cnt + 3'd1;
      for (int k = 0; k < SLOTS; k++)
        if (load_en[k]) slots[k] <= demux_out[k*DATA_W +: DATA_W];
      case (state)
        FILL: if (accept && fill_cnt == 3'd7) state <= FULL;
        FULL: if (win_ready) state <= FILL;
        default: state <= FILL;
      endcase
    end
  end

  assign win_valid = (state == FULL);
  assign win_data  = slots;

endmodule
